// File: rtl/sram_master.sv
// rtl/sram_master.sv - burst bus initiator for the single-port synchronous SRAM
//
// Accepts read/write burst requests (req_len+1 words) over a valid/ready
// handshake and sequences the SRAM pins. Writes take 1 word/cycle. Reads
// take 2 cycles/word: the address is held across RD_ADDR and RD_SAMPLE.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write, req_addr, req_len burst direction, start address, length-1
//   wdata/wdata_valid/wdata_ready write word stream
//   rdata, rdata_valid           registered read word, one-cycle pulse
//   done                         one-cycle pulse at burst completion
//   mem_cs/mem_we/mem_oe         registered SRAM controls
//   mem_address                  registered SRAM address
//   mem_data                     shared data bus, driven only while mem_we=1
module sram_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_FLUSH,
    S_RD_ADDR,
    S_RD_SAMPLE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LEN_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] wbuf_q, wbuf_nxt;
  logic              cs_nxt, we_nxt, oe_nxt;
  logic [ADDR_W-1:0] maddr_nxt;
  logic              done_nxt, rvalid_nxt;
  logic [DATA_W-1:0] rdata_nxt;

  assign req_ready   = (state == S_IDLE);
  assign wdata_ready = (state == S_WR);

  // Drive enable comes straight from the registered mem_we, so the master
  // can never drive while the SRAM has its output enabled.
  assign mem_data = mem_we ? wbuf_q : {DATA_W{1'bz}};

  // Pin values below are the values for the NEXT cycle; they are registered
  // so every SRAM control is glitch-free.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    cnt_nxt    = cnt_q;
    wbuf_nxt   = wbuf_q;
    cs_nxt     = 1'b0;
    we_nxt     = 1'b0;
    oe_nxt     = 1'b0;
    maddr_nxt  = mem_address;
    done_nxt   = 1'b0;
    rvalid_nxt = 1'b0;
    rdata_nxt  = rdata;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_nxt = req_addr;
          cnt_nxt  = req_len;
          if (req_write) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD_ADDR;
            cs_nxt    = 1'b1;
            oe_nxt    = 1'b1;
            maddr_nxt = req_addr;
          end
        end
      end

      S_WR: begin
        // No word offered: the next bus cycle is idle and the address holds.
        if (wdata_valid) begin
          wbuf_nxt  = wdata;
          cs_nxt    = 1'b1;
          we_nxt    = 1'b1;
          maddr_nxt = addr_q;
          addr_nxt  = addr_q + 1'b1;
          if (cnt_q == '0) begin
            state_nxt = S_WR_FLUSH;
          end else begin
            cnt_nxt = cnt_q - 1'b1;
          end
        end
      end

      S_WR_FLUSH: begin
        state_nxt = S_IDLE;
        done_nxt  = 1'b1;
      end

      S_RD_ADDR: begin
        cs_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        state_nxt = S_RD_SAMPLE;
      end

      S_RD_SAMPLE: begin
        rdata_nxt  = mem_data;
        rvalid_nxt = 1'b1;
        if (cnt_q == '0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt   = cnt_q - 1'b1;
          addr_nxt  = addr_q + 1'b1;
          maddr_nxt = addr_q + 1'b1;
          cs_nxt    = 1'b1;
          oe_nxt    = 1'b1;
          state_nxt = S_RD_ADDR;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      wbuf_q      <= '0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_address <= '0;
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      cnt_q       <= cnt_nxt;
      wbuf_q      <= wbuf_nxt;
      mem_cs      <= cs_nxt;
      mem_we      <= we_nxt;
      mem_oe      <= oe_nxt;
      mem_address <= maddr_nxt;
      done        <= done_nxt;
      rdata_valid <= rvalid_nxt;
      rdata       <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// tb/tb_sram_master.sv - self-checking bench for sram_master
module tb_sram_master;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_valid = 1'b0;
  logic          req_ready, wdata_ready, rdata_valid, done;
  logic [DW-1:0] rdata;
  logic          mem_cs, mem_we, mem_oe;
  logic [AW-1:0] mem_address;
  wire  [DW-1:0] mem_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] sram    [0:65535];
  logic [DW-1:0] sram_q;
  bit            loaded = 1'b0;
  logic          sram_drive;

  logic [DW-1:0] wq[$];
  int            sq[$];

  always #5 clk = ~clk;

  sram_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_address(mem_address), .mem_data(mem_data)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 40503) ^ 16'h3C5A;
  endfunction

  // Synchronous SRAM: registered output, drive gated by !we.
  assign sram_drive = mem_cs && mem_oe && !mem_we;
  assign mem_data   = sram_drive ? sram_q : 16'hzzzz;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) sram[i] <= init_val(i);
      loaded <= 1'b1;
    end else begin
      if (mem_cs && mem_we) sram[mem_address] <= mem_data;
      if (mem_cs && mem_oe && !mem_we) sram_q <= sram[mem_address];
    end
  end

  always @(negedge clk) begin
    vectors++;
    assert (!(mem_we && mem_oe)) else begin
      miscompares++;
      $error("FAIL contention: observed we=%b oe=%b expected never both 1", mem_we, mem_oe);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_bus(input logic cs, input logic we, input logic oe,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk("mem_cs", 32'(mem_cs), 32'(cs));
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_oe", 32'(mem_oe), 32'(oe));
    if (cs) chk("mem_address", 32'(mem_address), 32'(a));
    if (we) chk("mem_data", 32'(mem_data), 32'(d));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk_bus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Write burst of wq[0..len]; sq[i] idle cycles precede word i.
  task automatic do_write(input logic [AW-1:0] a, input int len);
    logic [AW-1:0] ad;
    int stall_total;
    ad = a;
    stall_total = 0;
    cyc = 0;
    chk("wr_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = LW'(len);
    tick();
    req_valid = 1'b0; req_addr = AW'($urandom); req_write = 1'b0;
    for (int i = 0; i <= len; i++) begin
      for (int s = 0; s < sq[i]; s++) begin
        wdata_valid = 1'b0;
        chk("wr_wready_stall", 32'(wdata_ready), 32'd1);
        tick();
        stall_total++;
        chk_bus(1'b0, 1'b0, 1'b0, '0, '0);
      end
      wdata_valid = 1'b1; wdata = wq[i];
      chk("wr_wready", 32'(wdata_ready), 32'd1);
      chk("wr_done_early", 32'(done), 32'd0);
      tick();
      chk_bus(1'b1, 1'b1, 1'b0, ad, wq[i]);
      ref_mem[ad] = wq[i];
      ad = ad + 1'b1;
    end
    wdata_valid = 1'b0; wdata = DW'($urandom);
    chk("wr_wready_flush", 32'(wdata_ready), 32'd0);
    chk("wr_done_flush", 32'(done), 32'd0);
    tick();
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_done_cycle", 32'(cyc), 32'(len + 3 + stall_total));
    chk("wr_req_ready_done", 32'(req_ready), 32'd1);
    chk_bus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int len);
    logic [AW-1:0] ad;
    ad = a;
    cyc = 0;
    chk("rd_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = LW'(len);
    tick();
    req_valid = 1'b0; req_addr = AW'($urandom); req_write = 1'b1;
    for (int i = 0; i <= len; i++) begin
      chk_bus(1'b1, 1'b0, 1'b1, ad, '0);
      chk("rd_wready", 32'(wdata_ready), 32'd0);
      tick();
      chk_bus(1'b1, 1'b0, 1'b1, ad, '0);
      chk("rd_rvalid_sample", 32'(rdata_valid), 32'd0);
      tick();
      chk("rd_rvalid", 32'(rdata_valid), 32'd1);
      chk("rd_rdata", 32'(rdata), 32'(ref_mem[ad]));
      chk("rd_done", 32'(done), 32'(i == len));
      ad = ad + 1'b1;
    end
    req_write = 1'b0;
    chk("rd_done_cycle", 32'(cyc), 32'(2 * len + 3));
    chk("rd_req_ready_done", 32'(req_ready), 32'd1);
    chk_bus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int len;
    logic [AW-1:0] a;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs();
    rst = 1'b0;
    tick();
    chk_reset_outputs();

    // Single write then read.
    wq = '{16'hBEEF}; sq = '{0};
    do_write(16'h0010, 0);
    do_read(16'h0010, 0);

    // Wrapping burst.
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444}; sq = '{0, 0, 0, 0};
    do_write(16'hFFFE, 3);
    do_read(16'hFFFE, 3);

    // Write stall of two cycles between words 1 and 2.
    wq = '{16'hA001, 16'hA002, 16'hA003}; sq = '{0, 0, 2};
    do_write(16'h0200, 2);
    do_read(16'h0200, 2);

    // Reset during word 2 of a 4-word write: words 0 and 1 reach the SRAM.
    cyc = 0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0300; req_len = 8'd3;
    tick();
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 16'hC000;
    tick();
    wdata = 16'hC001;
    tick();
    wdata = 16'hC002; rst = 1'b1;
    tick();
    rst = 1'b0; wdata_valid = 1'b0;
    ref_mem[16'h0300] = 16'hC000;
    ref_mem[16'h0301] = 16'hC001;
    chk_reset_outputs();
    do_read(16'h0300, 3);

    // Randomised back-to-back write/read bursts.
    for (int n = 0; n < 10; n++) begin
      len = int'($urandom_range(0, 7));
      a = ($urandom_range(0, 1) == 1) ? AW'(16'hFFFF - $urandom_range(0, 3)) : AW'($urandom);
      wq.delete();
      sq.delete();
      for (int i = 0; i <= len; i++) begin
        wq.push_back(DW'($urandom));
        sq.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      do_write(a, len);
      do_read(a, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
